// File: rtl/core_dbg_unit.sv
// Core debug controller sitting between the debug transport and one core pipeline.
//
// Host commands are handshaken by cmd_i (held until done_o) and sequenced by an FSM.
// The FSM requests a halt from the core and waits for its acknowledge (halted_i)
// whenever a command needs a quiescent core.
//
// Ports:
//   clk, rstn_i                    clock, asynchronous active-low reset
//   cmd_i, addr_i, data_i          host command, index operand and write data
//   data_o, done_o, err_o          read data, one-cycle completion pulse, reject flag
//   halt_core_o, halted_i          halt request to the core and its acknowledge
//   retire_i                       one instruction retired this cycle
//   if_pc_i, if_valid_i            fetch PC and its valid, used for breakpoint matching
//   pc_i                           PC of the halted core
//   rs_o, rs_di                    register-file debug read port
//   rd_o, rd_do, rd_we_o           register-file debug write port
//   pc_o, flush_o                  PC redirect and pipeline flush strobe
//   bp_hit_o                       sticky: core halted by a hardware breakpoint
module core_dbg_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NUM_BP = 2,
    localparam int unsigned RW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic            clk,
    input  logic            rstn_i,
    input  logic [7:0]      cmd_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] data_o,
    output logic            done_o,
    output logic            err_o,
    output logic            halt_core_o,
    input  logic            halted_i,
    input  logic            retire_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic            if_valid_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [RW-1:0]   rs_o,
    input  logic [XLEN-1:0] rs_di,
    output logic [RW-1:0]   rd_o,
    output logic [XLEN-1:0] rd_do,
    output logic            rd_we_o,
    output logic [XLEN-1:0] pc_o,
    output logic            flush_o,
    output logic            bp_hit_o
);

    localparam logic [7:0] CmdHalt   = 8'h01;
    localparam logic [7:0] CmdResume = 8'h02;
    localparam logic [7:0] CmdRdReg  = 8'h03;
    localparam logic [7:0] CmdWrReg  = 8'h04;
    localparam logic [7:0] CmdRdPc   = 8'h05;
    localparam logic [7:0] CmdWrPc   = 8'h06;
    localparam logic [7:0] CmdStep   = 8'h07;
    localparam logic [7:0] CmdSetBp  = 8'h08;
    localparam logic [7:0] CmdClrBp  = 8'h09;
    localparam logic [7:0] CmdStatus = 8'h0A;

    typedef enum logic [2:0] {
        StIdle,
        StHaltWait,
        StExec,
        StStepRun,
        StStepHalt,
        StDone,
        StClr
    } state_e;

    state_e state_q, state_d;

    logic [7:0]      cmd_q, cmd_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic            user_halt_q, user_halt_d;
    logic            tmp_halt_q, tmp_halt_d;
    logic            step_hold_q, step_hold_d;
    logic            skip_q, skip_d;
    logic            bp_hit_q, bp_hit_d;
    logic [2:0]      bp_idx_q, bp_idx_d;
    logic            halt_q, halt_d;
    logic [XLEN-1:0] bp_addr_q [NUM_BP];
    logic [XLEN-1:0] bp_addr_d [NUM_BP];
    logic [NUM_BP-1:0] bp_en_q, bp_en_d;

    logic            bp_match;
    logic [2:0]      bp_first;

    // Breakpoint compare; iterating downwards leaves the lowest matching index.
    always_comb begin
        bp_match = 1'b0;
        bp_first = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (if_valid_i && bp_en_q[i] && (if_pc_i == bp_addr_q[i])) begin
                bp_match = 1'b1;
                bp_first = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        err_d       = err_q;
        user_halt_d = user_halt_q;
        tmp_halt_d  = tmp_halt_q;
        step_hold_d = step_hold_q;
        skip_d      = skip_q;
        bp_hit_d    = bp_hit_q;
        bp_idx_d    = bp_idx_q;
        bp_addr_d   = bp_addr_q;
        bp_en_d     = bp_en_q;
        rd_we_o     = 1'b0;
        flush_o     = 1'b0;

        // The instruction sitting on a breakpoint has retired once anything retires.
        if (retire_i) begin
            skip_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_i != 8'h00) begin
                    cmd_d   = cmd_i;
                    addr_d  = addr_i;
                    wdata_d = data_i;
                    data_d  = '0;
                    err_d   = 1'b0;
                    state_d = StExec;
                    case (cmd_i)
                        CmdHalt: begin
                            user_halt_d = 1'b1;
                            state_d     = StHaltWait;
                        end
                        CmdResume, CmdStatus: begin
                        end
                        CmdRdReg, CmdWrReg: begin
                            if (addr_i >= XLEN'(NREGS)) begin
                                err_d = 1'b1;
                            end else begin
                                tmp_halt_d = 1'b1;
                                state_d    = StHaltWait;
                            end
                        end
                        CmdRdPc: begin
                            tmp_halt_d = 1'b1;
                            state_d    = StHaltWait;
                        end
                        CmdWrPc: begin
                            // Redirect only under a host halt; user_halt keeps the core stopped.
                            if (!user_halt_q) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = StHaltWait;
                            end
                        end
                        CmdStep: begin
                            if (!(user_halt_q && halted_i)) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = StStepRun;
                            end
                        end
                        CmdSetBp, CmdClrBp: begin
                            if (addr_i >= XLEN'(NUM_BP)) begin
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end

            StHaltWait: begin
                if (halted_i) begin
                    state_d = (cmd_q == CmdHalt) ? StDone : StExec;
                end
            end

            StExec: begin
                state_d = StDone;
                if (!err_q) begin
                    case (cmd_q)
                        CmdResume: begin
                            user_halt_d = 1'b0;
                            bp_hit_d    = 1'b0;
                            skip_d      = 1'b1;
                        end
                        CmdRdReg: begin
                            data_d = rs_di;
                        end
                        CmdWrReg: begin
                            // x0 is hardwired; the write is accepted but never issued.
                            rd_we_o = (addr_q[RW-1:0] != '0);
                        end
                        CmdRdPc: begin
                            data_d = pc_i;
                        end
                        CmdWrPc: begin
                            flush_o = 1'b1;
                        end
                        CmdSetBp: begin
                            for (int unsigned i = 0; i < NUM_BP; i++) begin
                                if (addr_q == XLEN'(i)) begin
                                    bp_addr_d[i] = wdata_q;
                                    bp_en_d[i]   = 1'b1;
                                end
                            end
                        end
                        CmdClrBp: begin
                            for (int unsigned i = 0; i < NUM_BP; i++) begin
                                if (addr_q == XLEN'(i)) begin
                                    bp_en_d[i] = 1'b0;
                                end
                            end
                        end
                        CmdStatus: begin
                            data_d = XLEN'({bp_idx_q, 1'b0, bp_hit_q, user_halt_q, halted_i});
                        end
                        default: begin
                        end
                    endcase
                end
            end

            StStepRun: begin
                if (retire_i) begin
                    step_hold_d = 1'b1;
                    state_d     = StStepHalt;
                end
            end

            StStepHalt: begin
                if (halted_i) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                tmp_halt_d  = 1'b0;
                step_hold_d = 1'b0;
                state_d     = StClr;
            end

            StClr: begin
                // Wait for the host to drop the command so it cannot run twice.
                if (cmd_i == 8'h00) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Evaluated last so a hit overrides a resume clearing user_halt in the same cycle.
        if (bp_match && !user_halt_q && !skip_q && (state_q != StStepRun)) begin
            user_halt_d = 1'b1;
            bp_hit_d    = 1'b1;
            bp_idx_d    = bp_first;
        end

        // While stepping the core is released even though user_halt stays set.
        halt_d = (state_d != StStepRun) && (user_halt_d || tmp_halt_d || step_hold_d);
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            user_halt_q <= 1'b0;
            tmp_halt_q  <= 1'b0;
            step_hold_q <= 1'b0;
            skip_q      <= 1'b0;
            bp_hit_q    <= 1'b0;
            bp_idx_q    <= '0;
            halt_q      <= 1'b0;
            bp_addr_q   <= '{default: '0};
            bp_en_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            err_q       <= err_d;
            user_halt_q <= user_halt_d;
            tmp_halt_q  <= tmp_halt_d;
            step_hold_q <= step_hold_d;
            skip_q      <= skip_d;
            bp_hit_q    <= bp_hit_d;
            bp_idx_q    <= bp_idx_d;
            halt_q      <= halt_d;
            bp_addr_q   <= bp_addr_d;
            bp_en_q     <= bp_en_d;
        end
    end

    assign done_o      = (state_q == StDone);
    assign err_o       = done_o && err_q;
    assign data_o      = data_q;
    assign halt_core_o = halt_q;
    assign bp_hit_o    = bp_hit_q;
    assign rs_o        = addr_q[RW-1:0];
    assign rd_o        = addr_q[RW-1:0];
    assign rd_do       = wdata_q;
    assign pc_o        = wdata_q;

endmodule

// File: tb/tb_core_dbg_unit.sv
// Scoreboard bench for core_dbg_unit: the stimulus pushes the expected completion
// (data, err) for each command; a monitor pops it on every done_o pulse.
module tb_core_dbg_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned NUM_BP = 2;
    localparam int unsigned RW     = 5;

    logic            clk;
    logic            rstn_i;
    logic [7:0]      cmd_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] data_i;
    logic [XLEN-1:0] data_o;
    logic            done_o;
    logic            err_o;
    logic            halt_core_o;
    logic            halted_i;
    logic            retire_i;
    logic [XLEN-1:0] if_pc_i;
    logic            if_valid_i;
    logic [XLEN-1:0] pc_i;
    logic [RW-1:0]   rs_o;
    logic [XLEN-1:0] rs_di;
    logic [RW-1:0]   rd_o;
    logic [XLEN-1:0] rd_do;
    logic            rd_we_o;
    logic [XLEN-1:0] pc_o;
    logic            flush_o;
    logic            bp_hit_o;

    core_dbg_unit #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NUM_BP (NUM_BP)
    ) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .cmd_i       (cmd_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .halt_core_o (halt_core_o),
        .halted_i    (halted_i),
        .retire_i    (retire_i),
        .if_pc_i     (if_pc_i),
        .if_valid_i  (if_valid_i),
        .pc_i        (pc_i),
        .rs_o        (rs_o),
        .rs_di       (rs_di),
        .rd_o        (rd_o),
        .rd_do       (rd_do),
        .rd_we_o     (rd_we_o),
        .pc_o        (pc_o),
        .flush_o     (flush_o),
        .bp_hit_o    (bp_hit_o)
    );

    // Register file model: x5 holds a marker, others a recognisable pattern.
    assign rs_di = (rs_o == 5'd5) ? 32'hDEAD_BEEF : (32'h1000_0000 | 32'(rs_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [XLEN-1:0] data;
        logic            err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn_i && done_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done_o), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_data"}, 64'(data_o), 64'(e.data));
                    check({e.name, "_err"}, 64'(err_o), 64'(e.err));
                end
            end
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic [7:0] c, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] d, input logic [XLEN-1:0] exp_data,
                         input logic exp_err);
        exp_t e;
        e.name = name;
        e.data = exp_data;
        e.err  = exp_err;
        sb.push_back(e);
        cmd_i  = c;
        addr_i = a;
        data_i = d;
    endtask

    // Waits (bounded) for done_o, checks latency counted in clock edges since the call,
    // records any write/flush strobe seen on the way, then releases the command.
    logic            we_seen, fl_seen;
    logic [RW-1:0]   we_idx;
    logic [XLEN-1:0] we_data, fl_pc;

    task automatic wait_done(input string name, input int exp_lat);
        int lat;
        lat     = 0;
        we_seen = 1'b0;
        fl_seen = 1'b0;
        while (lat < 40) begin
            step_clk();
            lat++;
            if (rd_we_o) begin
                we_seen = 1'b1;
                we_idx  = rd_o;
                we_data = rd_do;
            end
            if (flush_o) begin
                fl_seen = 1'b1;
                fl_pc   = pc_o;
            end
            if (done_o) break;
        end
        if (!done_o) check({name, "_timeout"}, 64'd0, 64'd1);
        else if (exp_lat >= 0) check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        cmd_i = 8'h00;
        step_clk();
        step_clk();
    endtask

    task automatic pulse_retire();
        retire_i = 1'b1;
        step_clk();
        retire_i = 1'b0;
    endtask

    task automatic fetch(input logic [XLEN-1:0] pc);
        if_pc_i    = pc;
        if_valid_i = 1'b1;
        step_clk();
        if_valid_i = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 64'({halt_core_o, done_o, err_o, rd_we_o, flush_o, bp_hit_o}),
              64'd0);
        check({name, "_data_o"}, 64'(data_o), 64'd0);
        check({name, "_pc_o"}, 64'(pc_o), 64'd0);
        check({name, "_rd_do"}, 64'(rd_do), 64'd0);
        check({name, "_idx"}, 64'({rs_o, rd_o}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        rstn_i     = 1'b0;
        cmd_i      = 8'h00;
        addr_i     = '0;
        data_i     = '0;
        halted_i   = 1'b0;
        retire_i   = 1'b0;
        if_pc_i    = '0;
        if_valid_i = 1'b0;
        pc_i       = 32'h0000_0200;
        repeat (3) step_clk();
        check_all_zero("reset");
        rstn_i = 1'b1;
        step_clk();

        // Halt a running core; acknowledge arrives later.
        issue("halt", 8'h01, '0, '0, '0, 1'b0);
        step_clk();
        check("halt_req_rise", 64'(halt_core_o), 64'd1);
        step_clk();
        step_clk();
        halted_i = 1'b1;
        wait_done("halt", 1);

        // Register and PC access with the core already halted.
        issue("wr_x7", 8'h04, 32'd7, 32'hCAFE_0007, '0, 1'b0);
        wait_done("wr_x7", 3);
        check("wr_x7_we", 64'(we_seen), 64'd1);
        check("wr_x7_port", 64'({we_idx, we_data}), 64'({5'd7, 32'hCAFE_0007}));

        issue("wr_x0", 8'h04, 32'd0, 32'h1234_5678, '0, 1'b0);
        wait_done("wr_x0", 3);
        check("wr_x0_no_we", 64'(we_seen), 64'd0);

        issue("wr_x40", 8'h04, 32'd40, 32'h1, '0, 1'b1);
        wait_done("wr_x40", 2);
        check("wr_x40_no_we", 64'(we_seen), 64'd0);

        issue("rd_pc", 8'h05, '0, '0, 32'h0000_0200, 1'b0);
        wait_done("rd_pc", 3);

        issue("wr_pc", 8'h06, '0, 32'h0000_0300, '0, 1'b0);
        wait_done("wr_pc", 3);
        check("wr_pc_flush", 64'(fl_seen), 64'd1);
        check("wr_pc_target", 64'(fl_pc), 64'h300);

        issue("status_halted", 8'h0A, '0, '0, 32'h3, 1'b0);
        wait_done("status_halted", 2);

        // Single step: release, one retire, re-halt.
        issue("step", 8'h07, '0, '0, '0, 1'b0);
        step_clk();
        check("step_release", 64'(halt_core_o), 64'd0);
        halted_i = 1'b0;
        step_clk();
        pulse_retire();
        check("step_rehalt", 64'(halt_core_o), 64'd1);
        step_clk();
        halted_i = 1'b1;
        wait_done("step", 1);
        check("step_still_halted", 64'(halt_core_o), 64'd1);

        issue("resume", 8'h02, '0, '0, '0, 1'b0);
        wait_done("resume", 2);
        check("resume_release", 64'(halt_core_o), 64'd0);
        halted_i = 1'b0;
        pulse_retire();

        issue("step_running", 8'h07, '0, '0, '0, 1'b1);
        wait_done("step_running", 2);

        // Register read from a running core uses a temporary halt.
        issue("rd_x5", 8'h03, 32'd5, '0, 32'hDEAD_BEEF, 1'b0);
        step_clk();
        check("rd_x5_tmp_halt", 64'(halt_core_o), 64'd1);
        halted_i = 1'b1;
        wait_done("rd_x5", 2);
        check("rd_x5_release", 64'(halt_core_o), 64'd0);
        halted_i = 1'b0;

        // Breakpoints.
        issue("set_bp1", 8'h08, 32'd1, 32'h0000_0100, '0, 1'b0);
        wait_done("set_bp1", 2);
        issue("set_bp2", 8'h08, 32'd2, 32'h0000_0180, '0, 1'b1);
        wait_done("set_bp2", 2);
        fetch(32'h0000_00FC);
        check("bp_miss", 64'({bp_hit_o, halt_core_o}), 64'd0);
        fetch(32'h0000_0100);
        check("bp_hit", 64'({bp_hit_o, halt_core_o}), 64'b11);
        halted_i = 1'b1;
        issue("status_bp", 8'h0A, '0, '0, 32'h17, 1'b0);
        wait_done("status_bp", 2);

        issue("resume_bp", 8'h02, '0, '0, '0, 1'b0);
        wait_done("resume_bp", 2);
        halted_i = 1'b0;
        fetch(32'h0000_0100);
        check("bp_skip", 64'({bp_hit_o, halt_core_o}), 64'd0);
        pulse_retire();
        fetch(32'h0000_0100);
        check("bp_rehit", 64'({bp_hit_o, halt_core_o}), 64'b11);
        halted_i = 1'b1;

        issue("clr_bp1", 8'h09, 32'd1, '0, '0, 1'b0);
        wait_done("clr_bp1", 2);
        issue("resume_clr", 8'h02, '0, '0, '0, 1'b0);
        wait_done("resume_clr", 2);
        halted_i = 1'b0;
        pulse_retire();
        fetch(32'h0000_0100);
        check("bp_cleared", 64'({bp_hit_o, halt_core_o}), 64'd0);

        issue("bad_cmd", 8'h5A, '0, '0, '0, 1'b1);
        wait_done("bad_cmd", 2);

        // Reset while waiting for the halt acknowledge aborts the command.
        issue("halt_aborted", 8'h01, '0, '0, '0, 1'b0);
        step_clk();
        #2;
        rstn_i = 1'b0;
        #1;
        sb.delete();
        cmd_i = 8'h00;
        check_all_zero("midcmd_reset");
        step_clk();
        rstn_i = 1'b1;
        repeat (3) step_clk();
        check("post_reset_quiet", 64'({done_o, halt_core_o}), 64'd0);

        // A command held well past completion must not run again.
        halted_i = 1'b1;
        issue("held_halt", 8'h01, '0, '0, '0, 1'b0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            step_clk();
            if (done_o) break;
        end
        check("held_halt_done", 64'(done_o), 64'd1);
        for (int i = 0; i < 10; i++) begin
            step_clk();
            if (done_o) extra++;
        end
        check("held_halt_single", 64'(extra), 64'd0);
        cmd_i = 8'h00;
        repeat (3) step_clk();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core_dbg_unit.md
# core_dbg_unit

Parametrised core debug controller between the debug transport and one core pipeline. It executes host commands: halt, resume, single-step, register-file read/write, PC read/write, hardware breakpoint set/clear, and status read. Width, register count and breakpoint count are parameters. It drives the core's halt request, the register-file debug port, and the PC-redirect/flush path. Command execution is sequenced by an FSM that waits for the core's halt acknowledge.

## Interface
- XLEN, 32, data/PC width
- NREGS, 32, architectural registers; RW = $clog2(NREGS)
- NUM_BP, 2, hardware PC breakpoints (1..8)

- clk  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- cmd_i  in  8  command code; 0 = none; held by host until done_o
- addr_i  in  XLEN  register index / breakpoint index
- data_i  in  XLEN  write data
- data_o  out  XLEN  read data; valid while done_o=1
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o; command rejected
- halt_core_o  out  1  halt request to core
- halted_i  in  1  core drained and halted
- retire_i  in  1  one instruction retired this cycle
- if_pc_i  in  XLEN  fetch PC
- if_valid_i  in  1  if_pc_i valid
- pc_i  in  XLEN  PC of the halted core
- rs_o  out  RW  register read index
- rs_di  in  XLEN  register read data (combinational from rs_o)
- rd_o  out  RW  register write index
- rd_do  out  XLEN  register write data
- rd_we_o  out  1  register write strobe
- pc_o  out  XLEN  redirect PC
- flush_o  out  1  redirect/flush strobe
- bp_hit_o  out  1  sticky: halted by breakpoint

## Operation
- FSM states: IDLE, HALT_WAIT, EXEC, STEP_RUN, STEP_HALT, DONE, CLR.
- IDLE: when cmd_i≠0, latch the command and go to HALT_WAIT, STEP_RUN, or EXEC as the command requires.
- DONE: pulse done_o (with err_o and data_o) for one cycle, then go to CLR.
- CLR: wait for cmd_i==0, then return to IDLE. A held command never re-executes.
- Registers:
  - user_halt: sticky halt set by the host.
  - tmp_halt: temporary halt for register/PC access.
  - halt_core_o = user_halt | tmp_halt | step_hold, registered.
- Commands:
  - 01 halt: set user_halt; HALT_WAIT until halted_i; DONE.
  - 02 resume: clear user_halt and bp_hit_o; arm the breakpoint-skip flag; DONE next cycle. Does not wait for the core.
  - 03 read reg: addr_i ≥ NREGS → err. Otherwise set tmp_halt; HALT_WAIT; EXEC drives rs_o=addr_i[RW-1:0] and captures data_o=rs_di; DONE clears tmp_halt.
  - 04 write reg: same index check and halt as 03. EXEC pulses rd_we_o for 1 cycle with rd_o/rd_do. A write to index 0 completes without err but rd_we_o stays 0.
  - 05 read PC: halt as 03; data_o=pc_i.
  - 06 write PC: requires user_halt=1, else err. Pulse flush_o for 1 cycle with pc_o=data_i.
  - 07 step: requires user_halt=1 and halted_i, else err.
    - STEP_RUN: halt released until the first retire_i; breakpoints are ignored.
    - STEP_HALT: halt re-asserted; wait for halted_i; DONE.
  - 08 set bp: index addr_i ≥ NUM_BP → err. Otherwise bp_addr[idx]=data_i, bp_en[idx]=1.
  - 09 clear bp: same index check; bp_en[idx]=0.
  - 0A status: data_o = {bp_idx[2:0] at [6:4], bp_hit at [2], user_halt at [1], halted_i at [0]}; other bits 0.
  - Any other code: DONE with err_o=1.
- Breakpoint hit:
  - Condition: if_valid_i & bp_en[i] & if_pc_i==bp_addr[i], with user_halt=0, skip flag clear, and not in STEP_RUN.
  - Effect: set user_halt, set bp_hit_o, record the lowest matching index in bp_idx.
  - The skip flag clears on the first retire_i after a resume.
- Set dominates: a breakpoint hit in the same cycle as resume's user_halt clear leaves user_halt=1.

## Timing
- Reset values (all outputs and state 0):
  - Outputs: halt_core_o, done_o, err_o, rd_we_o, flush_o, bp_hit_o, data_o, rs_o, rd_o, rd_do, pc_o.
  - State: FSM=IDLE, bp_en all 0, bp_addr 0, user_halt/tmp_halt/skip/step_hold = 0.
- Reset mid-command aborts it; no done_o is issued.
- cmd_i must be stable from acceptance to done_o. The command is latched, so a later change has no effect.
- Minimum latency, cmd_i seen in IDLE → done_o:
  - Resume, bp set/clear, status, error: 2 cycles.
  - Register/PC access with the core already halted: 3 cycles.
  - Halt waits are unbounded (no timeout).
- rd_we_o and flush_o are single-cycle and occur in EXEC, the cycle before done_o.
- halt_core_o rises one cycle after a breakpoint match, which leaves 1 cycle of fetch slip. The core must not retire the matched instruction.

## Test plan
- Halt with halted_i returned 3 cycles later → halt_core_o=1 next cycle, done_o 1 cycle after halted_i. Resume → halt_core_o=0, done_o, err_o=0.
- Running core; read reg 5 (rs_di=0xDEADBEEF) → temporary halt, data_o=0xDEADBEEF with done_o. halt_core_o then drops because user_halt=0.
- Write reg 0 → done, rd_we_o never 1. Write reg 40 with NREGS=32 → err_o=1.
- Set bp 1 at 0x100; fetch 0x100 → bp_hit_o=1 and status bits [6:4]=1. Resume at 0x100 → no immediate re-halt. The same bp hits again on the next fetch of 0x100.
- While halted, step → exactly one retire_i window, then re-halt and done. Step while running → err_o=1.
- Assert reset during HALT_WAIT → all outputs 0, no done_o. Hold cmd=01 for 10 cycles after done → only one done_o.
